dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline's MEM stage (CPU port) and an auxiliary master (debug/loader/dump engine).
- The CPU has default priority and a combinational pass-through path, so an uncontended load/store behaves exactly as a direct memory connection.
- The aux master uses a req/gnt handshake with registered read data.
- A wait counter guarantees forward progress for aux, and a burst limit bounds how long aux can stall the CPU.
- Sits between the datapath's DM_* signals and dmem; the datapath consumes cpu_stall to freeze the pipeline.

Parameters:
N, 64, data width.
ADDR_W, 6, memory word-index width; CPU byte address bits [ADDR_W+2:3].
AUX_WAIT_MAX, 8, cycles aux may wait before forced grant (≥1).
MAX_AUX_BURST, 4, max consecutive aux grants once forced (≥1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cpu_re  in  1  CPU read request.
cpu_we  in  1  CPU write request.
cpu_addr  in  N  CPU byte address.
cpu_wdata  in  N  CPU write data.
cpu_rdata  out  N  CPU read data (combinational from mem_rdata).
cpu_stall  out  1  CPU request not serviced this cycle.
aux_req  in  1  aux request; held with aux_we/addr/wdata stable until aux_gnt.
aux_we  in  1  aux write (1) / read (0).
aux_addr  in  ADDR_W  aux word index.
aux_wdata  in  N  aux write data.
aux_gnt  out  1  aux access performed this cycle.
aux_rdata  out  N  registered aux read data.
aux_valid  out  1  aux_rdata valid (one cycle).
mem_addr  out  ADDR_W  to dmem address.
mem_re  out  1  to dmem memRead.
mem_we  out  1  to dmem memWrite.
mem_wdata  out  N  to dmem writeData.
mem_rdata  in  N  from dmem readData (combinational read).

Behaviour:
- Reset (reset=0, async): state=CPU_PRI, wait_cnt=0, burst_cnt=0, aux_rdata=0, aux_valid=0. With no requests pending, all combinational outputs are 0.
- cpu_req = cpu_re | cpu_we. When cpu_re and cpu_we are both 1, the access is treated as a write (mem_we=1, mem_re=0).
- force = aux_req & (wait_cnt == AUX_WAIT_MAX).
- State CPU_PRI:
  - cpu_req & !force: CPU owns the memory.
  - otherwise, if aux_req: aux owns the memory. If the grant was caused by force, go to AUX_BURST with burst_cnt=1.
  - If neither requests: memory idle.
- State AUX_BURST:
  - aux_req: aux owns the memory, burst_cnt++.
  - Return to CPU_PRI (burst_cnt=0) when aux_req=0, or after the grant that makes burst_cnt == MAX_AUX_BURST. The next cycle serves the CPU even if aux_req is still 1.
- CPU owns: mem_addr=cpu_addr[ADDR_W+2:3], mem_re=cpu_re&!cpu_we, mem_we=cpu_we, mem_wdata=cpu_wdata, cpu_stall=0. cpu_rdata=mem_rdata at all times.
- Aux owns: aux_gnt=1, mem_addr=aux_addr, mem_we=aux_we, mem_re=!aux_we, mem_wdata=aux_wdata, cpu_stall=cpu_req.
- Idle: mem_re=mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, aux_gnt=0.
- wait_cnt:
  - increments each cycle with aux_req & !aux_gnt, saturating at AUX_WAIT_MAX;
  - clears on aux_gnt or when aux_req=0.
- Aux read response: a granted aux read at cycle T registers mem_rdata into aux_rdata at edge T+1, and aux_valid=1 for exactly cycle T+1. Aux writes produce no aux_valid. aux_rdata holds its value until the next aux read.
- Back-to-back aux grants allowed (one per cycle). aux_valid pulses follow grants with 1-cycle latency.
- Stalled CPU: the request stays asserted, as the pipeline is frozen. No CPU access is dropped or duplicated.
- Reset mid-burst: returns to CPU_PRI immediately, cancels any pending aux_valid, and sets aux_gnt=0.

Test Plan:
1. CPU write addr 0x18 data 0xDEAD, then read 0x18, no aux → mem_addr=3, cpu_stall=0 both cycles, cpu_rdata=0xDEAD.
2. Aux read idx 5 (mem[5]=0x1234), CPU idle → aux_gnt same cycle, aux_valid=1 and aux_rdata=0x1234 next cycle, single pulse.
3. CPU req every cycle plus aux_req from cycle 0 → aux_gnt first at cycle 8. cpu_stall=1 for cycles 8–11 if aux_req is held. Cycle 12 serves the CPU with aux_gnt=0, wait_cnt restarts.
4. Same as 3 but aux_req drops after 2 grants → returns to CPU_PRI; cpu_stall=1 only for those 2 cycles.
5. cpu_re=cpu_we=1 → mem_we=1, mem_re=0. Both requesting with wait_cnt<8 → CPU wins, wait_cnt increments.
6. Assert reset during AUX_BURST after a read grant → aux_valid=0, aux_rdata=0, state CPU_PRI. After release a pending CPU request is served at once.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the CPU MEM stage
//               (default priority, combinational pass-through) and an aux
//               master (req/gnt handshake, registered read data). A wait
//               counter forces aux service; a burst limit bounds CPU stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int N             = 64,
   parameter int ADDR_W        = 6,
   parameter int AUX_WAIT_MAX  = 8,
   parameter int MAX_AUX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [N-1:0]      cpu_addr,
   input  logic [N-1:0]      cpu_wdata,
   output logic [N-1:0]      cpu_rdata,
   output logic              cpu_stall,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [N-1:0]      aux_wdata,
   output logic              aux_gnt,
   output logic [N-1:0]      aux_rdata,
   output logic              aux_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [N-1:0]      mem_wdata,
   input  logic [N-1:0]      mem_rdata
);

   localparam int c_WAIT_W  = $clog2(AUX_WAIT_MAX + 1);
   localparam int c_BURST_W = $clog2(MAX_AUX_BURST + 1);

   localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX  = c_WAIT_W'(AUX_WAIT_MAX);
   localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE  = c_WAIT_W'(1);
   localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAX_AUX_BURST);
   localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);

   // Arbitration states
   localparam logic [0:0] c_CPU_PRI   = 1'b0;
   localparam logic [0:0] c_AUX_BURST = 1'b1;

   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic [c_WAIT_W-1:0]  r_wait_cnt;
   logic [c_WAIT_W-1:0]  w_wait_nxt;
   logic [c_BURST_W-1:0] r_burst_cnt;
   logic [c_BURST_W-1:0] w_burst_nxt;
   logic [N-1:0]         r_aux_rdata;
   logic                 r_aux_valid;

   logic w_cpu_req;
   logic w_force;
   logic w_cpu_own;
   logic w_aux_own;

   // Only the word-index bits of the CPU byte address reach the memory
   logic w_unused_addr_lo;
   assign w_unused_addr_lo = ^cpu_addr[2:0];

   generate
      if (N > ADDR_W + 3) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^cpu_addr[N-1:ADDR_W+3];
      end
   endgenerate

   assign w_cpu_req = cpu_re | cpu_we;
   assign w_force   = aux_req & (r_wait_cnt == c_WAIT_MAX);

   // Decide who owns the memory this cycle; nothing is granted while in reset
   always_comb begin
      w_cpu_own = 1'b0;
      w_aux_own = 1'b0;
      if (reset) begin
         if (r_state == c_AUX_BURST) begin
            if (aux_req) begin
               w_aux_own = 1'b1;
            end else begin
               // Aux let go early: the CPU gets this cycle without a bubble
               w_cpu_own = w_cpu_req;
            end
         end else if (w_cpu_req && !w_force) begin
            w_cpu_own = 1'b1;
         end else if (aux_req) begin
            w_aux_own = 1'b1;
         end
      end
   end

   // Next-state, burst length and aux starvation counter
   always_comb begin
      w_state_nxt = c_CPU_PRI;
      w_burst_nxt = '0;
      case (r_state)
         c_CPU_PRI: begin
            // A forced grant opens a burst unless the limit is a single grant
            if (w_aux_own && w_force && (c_BURST_MAX != c_BURST_ONE)) begin
               w_state_nxt = c_AUX_BURST;
               w_burst_nxt = c_BURST_ONE;
            end
         end
         c_AUX_BURST: begin
            if (aux_req && ((r_burst_cnt + c_BURST_ONE) != c_BURST_MAX)) begin
               w_state_nxt = c_AUX_BURST;
               w_burst_nxt = r_burst_cnt + c_BURST_ONE;
            end
         end
         default: begin
            w_state_nxt = c_CPU_PRI;
            w_burst_nxt = '0;
         end
      endcase

      if (!aux_req || w_aux_own) begin
         w_wait_nxt = '0;
      end else if (r_wait_cnt != c_WAIT_MAX) begin
         w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
      end else begin
         w_wait_nxt = r_wait_cnt;
      end
   end

   // Arbitration state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_CPU_PRI;
         r_wait_cnt  <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_nxt;
         r_burst_cnt <= w_burst_nxt;
      end
   end

   // Capture read data for granted aux reads; the value is held until the next one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_aux_rdata <= '0;
         r_aux_valid <= 1'b0;
      end else begin
         r_aux_valid <= w_aux_own & ~aux_we;
         if (w_aux_own && !aux_we) begin
            r_aux_rdata <= mem_rdata;
         end
      end
   end

   // Steer the memory port to the current owner; idle drives zeros
   always_comb begin
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (w_cpu_own) begin
         mem_addr  = cpu_addr[ADDR_W+2:3];
         mem_re    = cpu_re & ~cpu_we;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
      end else if (w_aux_own) begin
         mem_addr  = aux_addr;
         mem_re    = ~aux_we;
         mem_we    = aux_we;
         mem_wdata = aux_wdata;
      end
   end

   assign cpu_rdata = mem_rdata;
   assign cpu_stall = w_aux_own & w_cpu_req;
   assign aux_gnt   = w_aux_own;
   assign aux_rdata = r_aux_rdata;
   assign aux_valid = r_aux_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A behavioural model
//               (grant rules, wait/credit counters, reference memory) predicts
//               every output each cycle; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int N    = 64;
   localparam int AW   = 6;
   localparam int WMAX = 8;
   localparam int BMAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_re, cpu_we;
   logic [N-1:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          aux_req, aux_we;
   logic [AW-1:0] aux_addr;
   logic [N-1:0]  aux_wdata, aux_rdata;
   logic          aux_gnt, aux_valid;
   logic [AW-1:0] mem_addr;
   logic          mem_re, mem_we;
   logic [N-1:0]  mem_wdata, mem_rdata;

   logic [N-1:0] dut_mem [0:63];
   logic [N-1:0] ref_mem [0:63];

   int total = 0;
   int bad   = 0;

   // Model state: cycles aux has waited, forced grants still allowed in a burst
   int           m_wait    = 0;
   int           m_credits = 0;
   logic         m_valid   = 1'b0;
   logic [N-1:0] m_rdata   = '0;
   bit           e_aux, e_cpu;

   logic          ob_gnt, ob_stall, ob_valid, ob_re, ob_we;
   logic [AW-1:0] ob_addr;
   logic [N-1:0]  ob_rdata, ob_aux_rdata;

   dmem_arbiter #(.N(N), .ADDR_W(AW), .AUX_WAIT_MAX(WMAX), .MAX_AUX_BURST(BMAX)) dut (
      .clk(clk), .reset(reset),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_valid(aux_valid),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = dut_mem[mem_addr];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // One clock cycle: predict and check at negedge, advance model after posedge
   task automatic step();
      bit            creq, frc, dw;
      logic [AW-1:0] a, dwa;
      logic [N-1:0]  wd, dwd;
      bit            we_exp, re_exp;
      @(negedge clk);
      creq = cpu_re || cpu_we;
      frc  = aux_req && (m_wait == WMAX);
      if (m_credits > 0) e_aux = aux_req;
      else               e_aux = aux_req && (!creq || frc);
      e_cpu = !e_aux && creq;
      a = '0; wd = '0; we_exp = 1'b0; re_exp = 1'b0;
      if (e_cpu) begin
         a = AW'((cpu_addr / 8) % 64); wd = cpu_wdata; we_exp = cpu_we; re_exp = !cpu_we;
      end else if (e_aux) begin
         a = aux_addr; wd = aux_wdata; we_exp = aux_we; re_exp = !aux_we;
      end
      chk("mem_addr",  64'(mem_addr),  64'(a));
      chk("mem_re",    64'(mem_re),    64'(re_exp));
      chk("mem_we",    64'(mem_we),    64'(we_exp));
      chk("mem_wdata", mem_wdata,      wd);
      chk("aux_gnt",   64'(aux_gnt),   64'(e_aux));
      chk("cpu_stall", 64'(cpu_stall), 64'(e_aux && creq));
      chk("aux_valid", 64'(aux_valid), 64'(m_valid));
      chk("aux_rdata", aux_rdata,      m_rdata);
      chk("cpu_rdata", cpu_rdata,      ref_mem[a]);
      ob_gnt = aux_gnt; ob_stall = cpu_stall; ob_valid = aux_valid; ob_re = mem_re;
      ob_we = mem_we; ob_addr = mem_addr; ob_rdata = cpu_rdata; ob_aux_rdata = aux_rdata;
      dw = mem_we; dwa = mem_addr; dwd = mem_wdata;
      @(posedge clk);
      #1;
      if (dw) dut_mem[dwa] = dwd;
      m_valid = e_aux && !aux_we;
      if (m_valid) m_rdata = ref_mem[aux_addr];
      if (we_exp) ref_mem[a] = wd;
      if (m_credits > 0)     m_credits = aux_req ? m_credits - 1 : 0;
      else if (e_aux && frc) m_credits = BMAX - 1;
      if (!aux_req || e_aux) m_wait = 0;
      else if (m_wait < WMAX) m_wait = m_wait + 1;
   endtask

   initial begin
      int first_gnt, stalls, grants, pc, pa, r;
      bit gnt12, stalled, pending;
      logic [N-1:0] v;

      reset = 1'b0;
      cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         v = {$urandom, $urandom};
         dut_mem[i] = v;
         ref_mem[i] = v;
      end
      #3;
      chk("rst_valid", 64'(aux_valid), 64'(0));
      chk("rst_rdata", aux_rdata, 64'(0));
      chk("rst_gnt",   64'(aux_gnt), 64'(0));
      chk("rst_stall", 64'(cpu_stall), 64'(0));
      chk("rst_mem",   64'({mem_re, mem_we, mem_addr}), 64'(0));
      chk("rst_wdata", mem_wdata, 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // CPU write then read of byte address 0x18 with no aux traffic
      cpu_we = 1; cpu_addr = 64'h18; cpu_wdata = 64'hDEAD;
      step();
      chk("t1_waddr", 64'(ob_addr), 64'd3);
      chk("t1_wstall", 64'(ob_stall), 64'd0);
      cpu_we = 0; cpu_re = 1;
      step();
      chk("t1_raddr", 64'(ob_addr), 64'd3);
      chk("t1_rstall", 64'(ob_stall), 64'd0);
      chk("t1_rdata", ob_rdata, 64'hDEAD);

      // Aux writes 0x1234 to index 5, then reads it back
      cpu_re = 0;
      aux_req = 1; aux_we = 1; aux_addr = 6'd5; aux_wdata = 64'h1234;
      step();
      aux_we = 0;
      step();
      chk("t2_gnt", 64'(ob_gnt), 64'd1);
      aux_req = 0;
      step();
      chk("t2_valid", 64'(ob_valid), 64'd1);
      chk("t2_rdata", ob_aux_rdata, 64'h1234);
      step();
      chk("t2_pulse", 64'(ob_valid), 64'd0);

      // Continuous CPU traffic with aux held: forced grant at 8, burst to 11
      cpu_re = 1; cpu_addr = 64'h40; aux_req = 1;
      first_gnt = -1; stalls = 0; gnt12 = 1'b1;
      for (int c = 0; c < 13; c++) begin
         step();
         if (ob_gnt && first_gnt < 0) first_gnt = c;
         if (ob_stall) stalls++;
         if (c == 12) gnt12 = ob_gnt;
      end
      chk("t3_first", 64'(first_gnt), 64'd8);
      chk("t3_stalls", 64'(stalls), 64'd4);
      chk("t3_gnt12", 64'(gnt12), 64'd0);

      // Same, but aux drops after two grants
      aux_req = 0;
      step();
      aux_req = 1; grants = 0; stalls = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (ob_gnt) grants++;
         if (ob_stall) stalls++;
         if (grants == 2) aux_req = 0;
      end
      chk("t4_grants", 64'(grants), 64'd2);
      chk("t4_stalls", 64'(stalls), 64'd2);

      // Read+write together is a write; CPU wins while aux has not waited long
      cpu_re = 1; cpu_we = 1; cpu_addr = 64'h28; cpu_wdata = 64'hBEEF;
      step();
      chk("t5_we", 64'(ob_we), 64'd1);
      chk("t5_re", 64'(ob_re), 64'd0);
      aux_req = 1; aux_we = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t5_cpuwins", 64'(ob_gnt), 64'd0);
      end

      // Reset in the middle of a forced burst right after an aux read grant
      aux_req = 0; cpu_we = 0;
      step();
      aux_req = 1;
      for (int c = 0; c < 9; c++) step();
      chk("t6_pre_valid", 64'(aux_valid), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("t6_valid", 64'(aux_valid), 64'd0);
      chk("t6_rdata", aux_rdata, 64'd0);
      chk("t6_gnt", 64'(aux_gnt), 64'd0);
      m_wait = 0; m_credits = 0; m_valid = 1'b0; m_rdata = '0;
      #1 reset = 1'b1;
      step();
      chk("t6_served", 64'(ob_stall), 64'd0);
      chk("t6_nogrant", 64'(ob_gnt), 64'd0);

      // Random traffic; stalled CPU and pending aux requests hold their inputs
      for (int c = 0; c < 600; c++) begin
         case (c / 150)
            0:       begin pc = 90;  pa = 50;  end
            1:       begin pc = 100; pa = 90;  end
            2:       begin pc = 50;  pa = 50;  end
            default: begin pc = 95;  pa = 100; end
         endcase
         stalled = e_aux && (cpu_re || cpu_we);
         pending = aux_req && !e_aux;
         if (!stalled) begin
            r = int'($urandom_range(99));
            if (r < pc) begin
               case ($urandom_range(2))
                  0:       begin cpu_re = 1; cpu_we = 0; end
                  1:       begin cpu_re = 0; cpu_we = 1; end
                  default: begin cpu_re = 1; cpu_we = 1; end
               endcase
            end else begin
               cpu_re = 0; cpu_we = 0;
            end
            cpu_addr  = {$urandom, $urandom};
            cpu_wdata = {$urandom, $urandom};
         end
         if (!pending) begin
            aux_req   = (int'($urandom_range(99)) < pa);
            aux_we    = 1'($urandom_range(1));
            aux_addr  = AW'($urandom);
            aux_wdata = {$urandom, $urandom};
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
